// File: rtl/rv_ctrl_pkg.sv
// Shared constants for the multi-cycle RV32I control path:
// state encoding, opcodes, ALU codes and datapath mux codes.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_EXEC_LUI = 4'd4,
    S_WB_ALU   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_ILLEGAL  = 4'd12
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [4:0] ALU_ADDI  = 5'd0;
  localparam logic [4:0] ALU_SLTI  = 5'd1;
  localparam logic [4:0] ALU_SLTIU = 5'd2;
  localparam logic [4:0] ALU_XORI  = 5'd3;
  localparam logic [4:0] ALU_ORI   = 5'd4;
  localparam logic [4:0] ALU_ANDI  = 5'd5;
  localparam logic [4:0] ALU_SLLI  = 5'd6;
  localparam logic [4:0] ALU_SRLI  = 5'd7;
  localparam logic [4:0] ALU_SRAI  = 5'd8;
  localparam logic [4:0] ALU_ADD   = 5'd9;
  localparam logic [4:0] ALU_SUB   = 5'd10;
  localparam logic [4:0] ALU_SLL   = 5'd11;
  localparam logic [4:0] ALU_SLT   = 5'd12;
  localparam logic [4:0] ALU_SLTU  = 5'd13;
  localparam logic [4:0] ALU_XOR   = 5'd14;
  localparam logic [4:0] ALU_SRL   = 5'd15;
  localparam logic [4:0] ALU_SRA   = 5'd16;
  localparam logic [4:0] ALU_OR    = 5'd17;
  localparam logic [4:0] ALU_AND   = 5'd18;
  localparam logic [4:0] ALU_LUI   = 5'd19;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_RS1   = 2'd1;
  localparam logic [1:0] SRCA_OLDPC = 2'd2;
  localparam logic [1:0] SRCB_RS2   = 2'd0;
  localparam logic [1:0] SRCB_IMM   = 2'd1;
  localparam logic [1:0] SRCB_4     = 2'd2;
  localparam logic [1:0] WB_ALUOUT  = 2'd0;
  localparam logic [1:0] WB_MDR     = 2'd1;
  localparam logic [1:0] WB_PC      = 2'd2;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    unique case (op)
      OP_STORE:  imm_of = IMM_S;
      OP_BRANCH: imm_of = IMM_B;
      OP_LUI:    imm_of = IMM_U;
      OP_JAL:    imm_of = IMM_J;
      default:   imm_of = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_op_table.sv
// ALU operation lookup for register and immediate arithmetic.
// Non-arithmetic opcodes fall back to ADD.
module alu_op_table
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       inst30_i,
  output logic [4:0] alu_sel_o
);

  always_comb begin
    alu_sel_o = ALU_ADD;
    if (opcode_i == OP_R) begin
      unique case (funct3_i)
        3'b000: alu_sel_o = inst30_i ? ALU_SUB : ALU_ADD;
        3'b001: alu_sel_o = ALU_SLL;
        3'b010: alu_sel_o = ALU_SLT;
        3'b011: alu_sel_o = ALU_SLTU;
        3'b100: alu_sel_o = ALU_XOR;
        3'b101: alu_sel_o = inst30_i ? ALU_SRA : ALU_SRL;
        3'b110: alu_sel_o = ALU_OR;
        default: alu_sel_o = ALU_AND;
      endcase
    end else if (opcode_i == OP_I) begin
      unique case (funct3_i)
        3'b000: alu_sel_o = ALU_ADDI;
        3'b001: alu_sel_o = ALU_SLLI;
        3'b010: alu_sel_o = ALU_SLTI;
        3'b011: alu_sel_o = ALU_SLTIU;
        3'b100: alu_sel_o = ALU_XORI;
        3'b101: alu_sel_o = inst30_i ? ALU_SRAI : ALU_SRLI;
        3'b110: alu_sel_o = ALU_ORI;
        default: alu_sel_o = ALU_ANDI;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core.
// Outputs decode combinationally from state so reset drops them at once.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b1,
  parameter int STATE_W      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        Inst,
  input  logic               mem_ready,
  input  logic               alu_zero,
  input  logic               alu_lsb,
  output logic               mem_req,
  output logic               mem_we,
  output logic               IorD,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               PCSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [4:0]         ALUSel,
  output logic [2:0]         ImmSel,
  output logic               RegWrite,
  output logic [1:0]         WBSel,
  output logic               illegal,
  output logic [STATE_W-1:0] state_dbg
);

  state_e     state_q, state_d;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] arith_sel;
  logic       taken;
  logic       unused_inst;

  assign opcode      = Inst[6:0];
  assign funct3      = Inst[14:12];
  assign unused_inst = ^{Inst[31], Inst[29:15], Inst[11:7]};

  alu_op_table u_alu_op_table (
    .opcode_i  (opcode),
    .funct3_i  (funct3),
    .inst30_i  (Inst[30]),
    .alu_sel_o (arith_sel)
  );

  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    ALUSrcA  = SRCA_PC;
    ALUSrcB  = SRCB_RS2;
    ALUSel   = ALU_ADD;
    ImmSel   = imm_of(opcode);
    RegWrite = 1'b0;
    WBSel    = WB_ALUOUT;
    illegal  = 1'b0;
    taken    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        ALUSrcB = SRCB_4;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        unique case (opcode)
          OP_R:      state_d = S_EXEC_R;
          OP_I:      state_d = S_EXEC_I;
          OP_LUI:    state_d = S_EXEC_LUI;
          OP_LOAD:   state_d = S_MEM_ADDR;
          OP_STORE:  state_d = S_MEM_ADDR;
          OP_BRANCH: state_d = S_BRANCH;
          OP_JAL:    state_d = S_JAL;
          default:   state_d = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: begin
        ALUSrcA = SRCA_RS1;
        ALUSel  = arith_sel;
        state_d = S_WB_ALU;
      end
      S_EXEC_I: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUSel  = arith_sel;
        state_d = S_WB_ALU;
      end
      S_EXEC_LUI: begin
        ALUSrcB = SRCB_IMM;
        ALUSel  = ALU_LUI;
        state_d = S_WB_ALU;
      end
      S_WB_ALU: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_WB_MEM: begin
        RegWrite = 1'b1;
        WBSel    = WB_MDR;
        state_d  = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = SRCA_RS1;
        state_d = S_FETCH;
        unique case (funct3)
          3'b000: begin ALUSel = ALU_SUB;  taken = alu_zero;  end
          3'b001: begin ALUSel = ALU_SUB;  taken = !alu_zero; end
          3'b100: begin ALUSel = ALU_SLT;  taken = alu_lsb;   end
          3'b101: begin ALUSel = ALU_SLT;  taken = !alu_lsb;  end
          3'b110: begin ALUSel = ALU_SLTU; taken = alu_lsb;   end
          3'b111: begin ALUSel = ALU_SLTU; taken = !alu_lsb;  end
          default: state_d = S_ILLEGAL;
        endcase
        PCWrite = taken;
        PCSrc   = taken;
      end
      S_JAL: begin
        RegWrite = 1'b1;
        WBSel    = WB_PC;
        PCWrite  = 1'b1;
        PCSrc    = 1'b1;
        state_d  = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
        state_d = ILLEGAL_HALT ? S_ILLEGAL : S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Held reset masks every strobe so an abandoned access writes nothing
    if (!rst_n) begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      IorD     = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      PCSrc    = 1'b0;
      ALUSrcA  = SRCA_PC;
      ALUSrcB  = SRCB_RS2;
      ALUSel   = ALU_ADD;
      ImmSel   = IMM_I;
      RegWrite = 1'b0;
      WBSel    = WB_ALUOUT;
      illegal  = 1'b0;
    end
  end

  assign state_dbg = rst_n ? STATE_W'(state_q) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed and random instructions
// scored per instruction against a transaction-level model.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] Inst;
  logic        mem_ready, alu_zero, alu_lsb;
  logic        mem_req, mem_we, IorD, IRWrite, PCWrite, PCSrc;
  logic [1:0]  ALUSrcA, ALUSrcB, WBSel;
  logic [4:0]  ALUSel;
  logic [2:0]  ImmSel;
  logic        RegWrite, illegal;
  logic [3:0]  state_dbg;

  int n_assert = 0;
  int n_fail   = 0;

  multicycle_ctrl #(.ILLEGAL_HALT(1'b1), .STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .Inst(Inst),
    .mem_ready(mem_ready), .alu_zero(alu_zero), .alu_lsb(alu_lsb),
    .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUSel(ALUSel),
    .ImmSel(ImmSel), .RegWrite(RegWrite), .WBSel(WBSel),
    .illegal(illegal), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: mnemonic tables indexed by funct3
  function automatic int exp_exec_alu(input logic [31:0] ins);
    int itab [8] = '{0, 6, 1, 2, 3, 7, 4, 5};
    int rtab [8] = '{9, 11, 12, 13, 14, 15, 17, 18};
    int btab [8] = '{10, 10, 0, 0, 12, 12, 13, 13};
    int f3 = int'(ins[14:12]);
    case (ins[6:0])
      7'h33: begin
        if (f3 == 0 && ins[30]) return 10;
        if (f3 == 5 && ins[30]) return 16;
        return rtab[f3];
      end
      7'h13: return (f3 == 5 && ins[30]) ? 8 : itab[f3];
      7'h37: return 19;
      7'h63: return btab[f3];
      default: return 9;
    endcase
  endfunction

  function automatic int exp_imm(input logic [6:0] op);
    case (op)
      7'h23: return 1;
      7'h63: return 2;
      7'h37: return 3;
      7'h6F: return 4;
      default: return 0;
    endcase
  endfunction

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_alusel", ALUSel, 9);
    check("rst_pcwrite", PCWrite, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    #1;
    check("rel_state", state_dbg, 0);
    check("rel_mem_req", mem_req, 1);
  endtask

  // Runs one instruction from FETCH; caller is just past a posedge in FETCH
  task automatic run_instr(input logic [31:0] ins, input int kf, input int km,
                           input logic z, input logic l);
    logic [6:0] op = ins[6:0];
    int f3 = int'(ins[14:12]);
    bit is_ld = (op == 7'h03);
    bit is_st = (op == 7'h23);
    bit is_br = (op == 7'h63);
    bit is_jal = (op == 7'h6F);
    bit tk;
    int ecyc, erw, ewb, epcs, edm;
    int rw = 0, wbs = -1, pcw = 0, pcs = 0, irw = 0;
    int fcyc = 0, dcyc = 0, wecyc = 0;
    int since = -1, xalu = -1, ximm = -1;
    int acc = 0, stall = 0, need;
    case (f3)
      0: tk = z;
      1: tk = !z;
      4, 6: tk = l;
      default: tk = !l;
    endcase
    tk = tk && is_br;
    edm  = (is_ld || is_st) ? km + 1 : 0;
    ecyc = is_ld ? 5 + kf + km : is_st ? 4 + kf + km :
           (is_br || is_jal) ? 3 + kf : 4 + kf;
    erw  = (is_st || is_br) ? 0 : 1;
    ewb  = is_ld ? 1 : is_jal ? 2 : (erw != 0) ? 0 : -1;
    epcs = (is_jal || tk) ? 1 : 0;
    Inst = ins; alu_zero = z; alu_lsb = l;
    for (int c = 0; c < ecyc; c++) begin
      @(negedge clk);
      need = (acc == 0) ? kf : (acc == 1) ? km : 0;
      mem_ready = mem_req ? (stall == need) : 1'($urandom);
      #1;
      if (RegWrite) begin rw++; wbs = int'(WBSel); end
      if (PCWrite) pcw++;
      if (PCWrite && PCSrc) pcs++;
      if (IRWrite) irw++;
      if (mem_req && !IorD) fcyc++;
      if (mem_req && IorD) dcyc++;
      if (mem_req && mem_we) wecyc++;
      if (since >= 0) since++;
      if (IRWrite) since = 0;
      if (since == 2) begin xalu = int'(ALUSel); ximm = int'(ImmSel); end
      if (mem_req) begin
        if (mem_ready) begin acc++; stall = 0; end
        else stall++;
      end
    end
    check("regwrite_cnt", rw, erw);
    check("wbsel", wbs, ewb);
    check("pcwrite_cnt", pcw, 1 + epcs);
    check("pcsrc1_cnt", pcs, epcs);
    check("irwrite_cnt", irw, 1);
    check("fetch_req_cycles", fcyc, kf + 1);
    check("data_req_cycles", dcyc, edm);
    check("we_cycles", wecyc, is_st ? km + 1 : 0);
    check("exec_alusel", xalu, exp_exec_alu(ins));
    check("exec_immsel", ximm, exp_imm(op));
    @(posedge clk); #1;
    n_assert++;
    assert (state_dbg === 4'd0) else begin
      n_fail++;
      $error("FAIL back_to_fetch: observed %0d expected 0 ins=%h", state_dbg, ins);
      do_reset();
    end
  endtask

  logic [31:0] ins;
  int cls;
  int bf3 [6] = '{0, 1, 4, 5, 6, 7};
  logic [6:0] ops [7] = '{7'h33, 7'h13, 7'h37, 7'h03, 7'h23, 7'h63, 7'h6F};

  initial begin
    rst_n = 1'b0; Inst = '0; mem_ready = 1'b0;
    alu_zero = 1'b0; alu_lsb = 1'b0;
    #2;
    check("reset_mem_req", mem_req, 0);
    check("reset_alusel", ALUSel, 9);
    check("reset_state", state_dbg, 0);
    check("reset_irwrite", IRWrite, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    #1;
    check("fetch_alusrcb", ALUSrcB, 2);
    check("fetch_mem_req", mem_req, 1);

    run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0);
    run_instr(32'h4020D093, 0, 0, 1'b0, 1'b0);
    run_instr(32'h40208033, 0, 0, 1'b0, 1'b0);
    run_instr(32'h0000A103, 0, 3, 1'b0, 1'b0);
    run_instr(32'h00208463, 0, 0, 1'b1, 1'b0);
    run_instr(32'h00209463, 0, 0, 1'b1, 1'b0);
    run_instr(32'h0080006F, 2, 0, 1'b0, 1'b1);
    run_instr(32'h0020A223, 1, 2, 1'b0, 1'b0);
    run_instr(32'h123450B7, 0, 0, 1'b0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      cls = $urandom_range(0, 6);
      ins = $urandom;
      ins[6:0] = ops[cls];
      if (cls == 5) ins[14:12] = 3'(bf3[$urandom_range(0, 5)]);
      run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), 1'($urandom));
    end

    Inst = 32'h0000007F;
    repeat (2) begin @(negedge clk); mem_ready = 1'b1; end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); mem_ready = 1'($urandom);
      #1;
      check("halt_illegal", illegal, 1);
      check("halt_no_req", mem_req, 0);
    end
    do_reset();

    Inst = 32'h0020A063;
    repeat (3) begin @(negedge clk); mem_ready = 1'b1; end
    @(negedge clk); #1;
    check("br_f3_010_illegal", illegal, 1);
    do_reset();

    Inst = 32'h0020A223;
    repeat (3) begin @(negedge clk); mem_ready = 1'b1; end
    @(negedge clk); mem_ready = 1'b0;
    #1;
    check("memwr_we_pre", mem_we, 1);
    #2 rst_n = 1'b0;
    #1;
    check("memwr_rst_req", mem_req, 0);
    check("memwr_rst_we", mem_we, 0);
    check("memwr_rst_alusel", ALUSel, 9);
    @(posedge clk); #1 rst_n = 1'b1;
    #1;
    check("post_rst_state", state_dbg, 0);
    check("post_rst_req", mem_req, 1);
    check("post_rst_alusel", ALUSel, 9);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
